// File: rtl/pio_in_edge_irq_pkg.sv
// Shared definitions for the edge-capturing input PIO: register map, edge encodings
// and the counter sizing helper used by the debounce filter.
package pio_in_edge_irq_pkg;

    localparam int ADDR_W = 2;
    localparam int DATA_W = 32;

    typedef enum logic [ADDR_W-1:0] {
        ADDR_DATA    = 2'd0,
        ADDR_RSVD    = 2'd1,
        ADDR_IRQMASK = 2'd2,
        ADDR_EDGECAP = 2'd3
    } reg_addr_e;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // Debounce counter width: clog2(cycles+1), never narrower than one bit.
    function automatic int cnt_width(input int debounce_cycles);
        int w;
        w = $clog2(debounce_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pio_in_edge_irq_if.sv
// Avalon-MM slave bus bundle for the input PIO (address, select, write strobe, data).
interface pio_in_edge_irq_if;
    import pio_in_edge_irq_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/pio_in_edge_irq_debounce.sv
// Single-bit debounce filter: stable follows s only after s has disagreed with it
// for max(DEBOUNCE_CYCLES,1) consecutive cycles; toggle flags the cycle before it flips.
module pio_debounce_bit
    import pio_in_edge_irq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic s,
    output logic stable,
    output logic toggle
);

    localparam int                TARGET   = (DEBOUNCE_CYCLES > 1) ? DEBOUNCE_CYCLES : 1;
    localparam int                CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TARGET - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        cnt_d  = cnt_q;
        toggle = 1'b0;
        if (s == stable) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            toggle = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            stable <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (toggle) begin
                stable <= ~stable;
            end
        end
    end

endmodule

// File: rtl/pio_in_edge_irq.sv
// Input PIO with synchroniser, per-bit debounce, edge capture (write-1-to-clear),
// interrupt mask and a level interrupt.
module pio_in_edge_irq
    import pio_in_edge_irq_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0,
    parameter int EDGE_TYPE       = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    pio_in_edge_irq_if.slave  bus,
    input  logic [WIDTH-1:0]  in_port,
    output logic              irq
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  s;
    logic [WIDTH-1:0]                  stable;
    logic [WIDTH-1:0]                  toggle;
    logic [WIDTH-1:0]                  edge_set;
    logic [WIDTH-1:0]                  edgecap_clr;
    logic [WIDTH-1:0]                  edgecap_q;
    logic [WIDTH-1:0]                  irqmask_q;
    logic [WIDTH-1:0]                  wdata;
    logic                              wr_en;
    logic [DATA_W-1:0]                 rd_mux;
    logic                              unused_wdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    for (genvar i = 0; i < WIDTH; i++) begin : g_debounce
        pio_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .reset_n(reset_n),
            .s      (s[i]),
            .stable (stable[i]),
            .toggle (toggle[i])
        );
    end

    // toggle is asserted the cycle before stable flips, so the current stable value
    // tells the direction of the transition landing on the coming edge.
    always_comb begin
        case (EDGE_TYPE)
            EDGE_FALL: edge_set = toggle & stable;
            EDGE_ANY:  edge_set = toggle;
            default:   edge_set = toggle & ~stable;
        endcase
    end

    assign wr_en        = bus.chipselect & ~bus.write_n;
    assign wdata        = bus.writedata[WIDTH-1:0];
    assign unused_wdata = ^bus.writedata;
    assign edgecap_clr  = (wr_en && bus.address == ADDR_EDGECAP) ? wdata : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask_q <= '0;
            edgecap_q <= '0;
        end else begin
            if (wr_en && bus.address == ADDR_IRQMASK) begin
                irqmask_q <= wdata;
            end
            // Set is OR-ed after the clear so a capture coinciding with a W1C survives.
            edgecap_q <= (edgecap_q & ~edgecap_clr) | edge_set;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            ADDR_DATA:    rd_mux[WIDTH-1:0] = stable;
            ADDR_IRQMASK: rd_mux[WIDTH-1:0] = irqmask_q;
            ADDR_EDGECAP: rd_mux[WIDTH-1:0] = edgecap_q;
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.readdata <= '0;
        end else begin
            bus.readdata <= rd_mux;
        end
    end

    assign irq = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// Directed bench: four instances (default, debounce 4, falling edge, any edge) share
// one Avalon master; each has its own in_port and readdata/irq observation.
module tb_pio_in_edge_irq;
    import pio_in_edge_irq_pkg::*;

    logic       clk;
    logic       reset_n;
    logic [7:0] in0, in1, in2, in3;
    logic       irq0, irq1, irq2, irq3;
    int         passed = 0;
    int         total  = 0;

    pio_in_edge_irq_if bus0 ();
    pio_in_edge_irq_if bus1 ();
    pio_in_edge_irq_if bus2 ();
    pio_in_edge_irq_if bus3 ();

    assign bus1.address = bus0.address;  assign bus1.chipselect = bus0.chipselect;
    assign bus1.write_n = bus0.write_n;  assign bus1.writedata  = bus0.writedata;
    assign bus2.address = bus0.address;  assign bus2.chipselect = bus0.chipselect;
    assign bus2.write_n = bus0.write_n;  assign bus2.writedata  = bus0.writedata;
    assign bus3.address = bus0.address;  assign bus3.chipselect = bus0.chipselect;
    assign bus3.write_n = bus0.write_n;  assign bus3.writedata  = bus0.writedata;

    pio_in_edge_irq #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0)) dut_def (
        .clk(clk), .reset_n(reset_n), .bus(bus0), .in_port(in0), .irq(irq0));
    pio_in_edge_irq #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) dut_db (
        .clk(clk), .reset_n(reset_n), .bus(bus1), .in_port(in1), .irq(irq1));
    pio_in_edge_irq #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(1)) dut_fall (
        .clk(clk), .reset_n(reset_n), .bus(bus2), .in_port(in2), .irq(irq2));
    pio_in_edge_irq #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2)) dut_any (
        .clk(clk), .reset_n(reset_n), .bus(bus3), .in_port(in3), .irq(irq3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus0.address    = a;
        bus0.writedata  = d;
        bus0.chipselect = 1'b1;
        bus0.write_n    = 1'b0;
        tick(1);
        bus0.chipselect = 1'b0;
        bus0.write_n    = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a);
        bus0.address = a;
        tick(1);
    endtask

    initial begin
        reset_n = 1'b0;
        in0 = 8'h00; in1 = 8'h00; in2 = 8'h00; in3 = 8'h00;
        bus0.address = ADDR_DATA; bus0.chipselect = 1'b0;
        bus0.write_n = 1'b1;      bus0.writedata  = 32'h0;
        tick(2);
        check("reset_readdata", bus0.readdata, 32'h0);
        check("reset_irq", {31'h0, irq0}, 32'h0);
        reset_n = 1'b1;
        tick(2);

        // Default latency: change held before edge k shows on readdata at k+3.
        in0 = 8'hA5;
        tick(3);
        check("data_k_plus_2", bus0.readdata, 32'h0);
        tick(1);
        check("data_k_plus_3", bus0.readdata, 32'h0000_00A5);
        rd(ADDR_EDGECAP);
        check("edgecap_a5", bus0.readdata, 32'h0000_00A5);
        rd(ADDR_RSVD);
        check("addr1_reads_0", bus0.readdata, 32'h0);
        bus_write(ADDR_DATA, 32'hFFFF_FFFF);
        rd(ADDR_DATA);
        check("data_write_ignored", bus0.readdata, 32'h0000_00A5);

        // Interrupt on bit 0, clear, then masked capture on bit 4.
        bus_write(ADDR_EDGECAP, 32'hFF);
        bus_write(ADDR_IRQMASK, 32'h01);
        check("irq_after_mask_write", {31'h0, irq0}, 32'h0);
        rd(ADDR_IRQMASK);
        check("irqmask_rd", bus0.readdata, 32'h01);
        in0 = 8'hA4;
        tick(4);
        check("no_irq_on_fall", {31'h0, irq0}, 32'h0);
        in0 = 8'hA5;
        tick(2);
        check("irq_before_capture", {31'h0, irq0}, 32'h0);
        tick(1);
        check("irq_on_capture", {31'h0, irq0}, 32'h1);
        bus_write(ADDR_EDGECAP, 32'h01);
        check("irq_after_w1c", {31'h0, irq0}, 32'h0);
        in0 = 8'hB5;
        tick(4);
        check("irq_masked_bit4", {31'h0, irq0}, 32'h0);
        rd(ADDR_EDGECAP);
        check("edgecap_bit4", bus0.readdata, 32'h10);

        // W1C of bit 0 on the very edge a new rise on bit 0 is captured.
        in0 = 8'hB4;
        tick(4);
        bus_write(ADDR_EDGECAP, 32'hFF);
        check("irq_cleared_pre_collide", {31'h0, irq0}, 32'h0);
        in0 = 8'hB5;
        tick(2);
        bus_write(ADDR_EDGECAP, 32'h01);
        check("setwins_irq", {31'h0, irq0}, 32'h1);
        rd(ADDR_EDGECAP);
        check("setwins_edgecap", bus0.readdata, 32'h01);

        // Debounce 4: 3-cycle pulse filtered, 6-cycle pulse accepted.
        in1 = 8'h04;
        tick(3);
        in1 = 8'h00;
        tick(8);
        rd(ADDR_DATA);
        check("db_short_data", bus1.readdata, 32'h0);
        rd(ADDR_EDGECAP);
        check("db_short_edgecap", bus1.readdata, 32'h0);
        bus0.address = ADDR_DATA;
        in1 = 8'h04;
        tick(6);
        check("db_long_before", bus1.readdata, 32'h0);
        in1 = 8'h00;
        tick(1);
        check("db_long_data", bus1.readdata, 32'h04);
        tick(10);
        check("db_long_released", bus1.readdata, 32'h0);
        rd(ADDR_EDGECAP);
        check("db_long_edgecap", bus1.readdata, 32'h04);

        // Falling-only and any-edge capture on bit 7.
        in2 = 8'h80; in3 = 8'h80;
        tick(4);
        rd(ADDR_EDGECAP);
        check("fall_on_rise", bus2.readdata, 32'h0);
        check("any_on_rise", bus3.readdata, 32'h80);
        bus_write(ADDR_EDGECAP, 32'hFF);
        rd(ADDR_EDGECAP);
        check("any_cleared", bus3.readdata, 32'h0);
        in2 = 8'h00; in3 = 8'h00;
        tick(4);
        rd(ADDR_EDGECAP);
        check("fall_on_fall", bus2.readdata, 32'h80);
        check("any_on_fall", bus3.readdata, 32'h80);

        // Reset mid-operation discards edges, mask and pending debounce.
        in0 = 8'h00;
        tick(5);
        bus_write(ADDR_EDGECAP, 32'hFF);
        in0 = 8'hFF;
        tick(5);
        rd(ADDR_EDGECAP);
        check("pre_reset_edgecap", bus0.readdata, 32'hFF);
        check("pre_reset_irq", {31'h0, irq0}, 32'h1);
        in1 = 8'hFF;
        tick(4);
        reset_n = 1'b0;
        #1;
        check("reset_async_readdata", bus0.readdata, 32'h0);
        check("reset_async_irq", {31'h0, irq0}, 32'h0);
        tick(2);
        reset_n = 1'b1;
        tick(6);
        check("post_reset_irq", {31'h0, irq0}, 32'h0);
        rd(ADDR_EDGECAP);
        check("post_reset_edgecap", bus0.readdata, 32'hFF);
        rd(ADDR_IRQMASK);
        check("post_reset_mask", bus0.readdata, 32'h0);
        tick(10);
        rd(ADDR_DATA);
        check("post_reset_db_data", bus1.readdata, 32'hFF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pio_in_edge_irq.md
Name: pio_in_edge_irq

Overview:
- Parametrised successor to the single-register switch input PIO: an Avalon-MM slave that samples a WIDTH-bit asynchronous input bus (switches, keys).
- Adds a metastability synchroniser, optional per-bit debounce, per-bit edge capture with write-1-to-clear, an interrupt mask, and a level interrupt to the Nios II.
- Sits between the board pins and the system interconnect, alongside the existing PIO peripherals.

Parameters:
- WIDTH, 8, input bus width, legal range 1..32.
- SYNC_STAGES, 2, synchroniser flop count, legal range 2..4.
- DEBOUNCE_CYCLES, 0, consecutive cycles of disagreement required before the stable value updates. Values 0 and 1 behave identically: no filtering.
- EDGE_TYPE, 0, which stable-value transition sets edgecapture: 0 = rising, 1 = falling, 2 = any.

Ports:
- clk, input, 1, system clock.
- reset_n, input, 1, asynchronous active-low reset.
- address, input, 2, register select.
- chipselect, input, 1, slave select.
- write_n, input, 1, active-low write strobe.
- writedata, input, 32, write data.
- in_port, input, WIDTH, asynchronous pin inputs.
- readdata, output, 32, registered read data.
- irq, output, 1, level interrupt, active high.

Behaviour:
- Reset (asynchronous, reset_n low) clears all of the following to 0: synchroniser flops, debounce counters, stable, irqmask, edgecapture, readdata. irq is therefore 0.
- Register map:
  - 0: DATA, read-only, returns stable zero-extended to 32 bits. Writes are ignored.
  - 1: reads 0, writes ignored. No direction register.
  - 2: IRQMASK, read/write, WIDTH bits.
  - 3: EDGECAPTURE. Read returns the captured bits. A write clears each bit where writedata is 1.
- A write occurs on a clock edge where chipselect=1 and write_n=0. Only writedata[WIDTH-1:0] is used. Upper readdata bits are always 0.
- Read path: readdata <= mux(address) on every clock edge, with no read strobe. Read latency is 1 cycle from address. Reads have no side effects.
- Synchroniser: in_port passes through SYNC_STAGES flops. s is the output of the last stage.
- Debounce, per bit (instance of the sub-module):
  - Counter width is clog2(DEBOUNCE_CYCLES+1), minimum 1.
  - If s == stable, the counter resets to 0.
  - Otherwise the counter increments. When it would reach max(DEBOUNCE_CYCLES,1), stable <= s and the counter resets to 0.
  - Any glitch shorter than DEBOUNCE_CYCLES restarts the count and leaves stable unchanged.
- Latency: if in_port changes and holds before edge k, stable updates at edge k+SYNC_STAGES+max(DEBOUNCE_CYCLES,1)-1. DATA is visible on readdata one edge after that.
- Edge capture: on the same edge stable[i] transitions in the EDGE_TYPE direction, edgecapture[i] <= 1.
- If a write-1-clear to bit i and a new capture on bit i fall on the same edge, the set wins and the bit stays 1.
- irq = |(edgecapture & irqmask). It is combinational from registers, so it follows the register update in the same cycle. irq deasserts the cycle after the clear or mask write.
- Because stable resets to 0, an input held high through reset release produces a rising edge (EDGE_TYPE 0 or 2) once the synchroniser and debounce settle. This is required behaviour. Software masks it by clearing EDGECAPTURE before enabling irqmask.
- Reset asserted mid-debounce or mid-capture discards all state immediately. No pending edge survives reset.

Decomposition:
- Shared package holds:
  - register address constants: ADDR_DATA=0, ADDR_IRQMASK=2, ADDR_EDGECAP=3
  - EDGE_TYPE encodings: EDGE_RISE=0, EDGE_FALL=1, EDGE_ANY=2
- One sub-module: pio_debounce_bit (clk, reset_n, s, stable), parametrised by DEBOUNCE_CYCLES. The top level instantiates it WIDTH times in a generate loop.

Test Plan:
- Defaults (WIDTH=8, SYNC_STAGES=2, DEBOUNCE_CYCLES=0, EDGE_TYPE=0): in_port 0x00->0xA5 held before edge k, address=0 -> readdata=0x000000A5 from edge k+3, 0 before. EDGECAPTURE reads 0xA5.
- Interrupt: write IRQMASK=0x01, then raise in_port[0] -> irq=1 on the capture edge. Write 0x01 to address 3 -> irq=0 the next cycle. A second capture on bit 4 (mask 0) leaves irq=0.
- Set-wins collision: time a W1C of bit 0 to land on the same edge as a new rising capture on bit 0 -> EDGECAPTURE bit 0 remains 1 and irq stays 1.
- DEBOUNCE_CYCLES=4: 3-cycle pulse on in_port[2] -> DATA unchanged, no capture. 6-cycle pulse -> DATA bit 2 = 1 at edge k+SYNC_STAGES+3, captured.
- EDGE_TYPE=1 and EDGE_TYPE=2: toggle in_port[7] 0->1->0 -> EDGECAPTURE[7] set only on the fall (type 1), or set on both transitions with a clear in between (type 2).
- Reset mid-operation: assert reset_n=0 mid-debounce with edgecapture=0xFF and irq=1 -> all outputs 0 immediately. Release with in_port=0xFF -> rising captures reappear after settling, and irq stays 0 because the mask is 0.
